// File: rtl/fifo_sync_pf.sv
// Synchronous single-clock FIFO (any DEPTH >= 2) with occupancy count, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; default build uses a registered read port.
module fifo_sync_pf #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_THR = 14,
  parameter int ALMOST_MTY_THR  = 2,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  mty,
  output logic                  almost_mty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_mty;
  logic                  r_almost_mty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_count_next;

  // Acceptance is judged on the registered flags, so full+wr+rd favours the read
  // and empty+wr+rd favours the write without any extra arbitration.
  assign w_wr_acc     = wr & ~r_full;
  assign w_rd_acc     = rd & ~r_mty;
  assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_mty         <= 1'b1;
      r_almost_mty  <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count       <= w_count_next;
      r_full        <= (w_count_next == CW'(DEPTH));
      r_almost_full <= (w_count_next >= CW'(ALMOST_FULL_THR));
      r_mty         <= (w_count_next == '0);
      r_almost_mty  <= (w_count_next <= CW'(ALMOST_MTY_THR));
      if (wr & r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd & r_mty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign q       = r_mem[r_rd_ptr];
  assign q_valid = ~r_mty;
`else
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_q_valid;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_q <= r_mem[r_rd_ptr];
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
`endif

  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign mty         = r_mty;
  assign almost_mty  = r_almost_mty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_sync_pf.sv
// Bench for fifo_sync_pf: DEPTH=16 and DEPTH=5 instances checked against a queue model.
// Honours FIFO_FWFT_EN when building the expected read-port behaviour.
module tb_fifo_sync_pf;

  logic clk;
  logic srst;

  logic       wr_a, rd_a, wr_b, rd_b;
  logic [7:0] data_a, data_b;
  logic [7:0] q_a, q_b;
  logic       qv_a, full_a, af_a, mty_a, am_a, of_a, uf_a;
  logic       qv_b, full_b, af_b, mty_b, am_b, of_b, uf_b;
  logic [4:0] count_a;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  int depth [2] = '{16, 5};
  int af_thr[2] = '{14, 4};
  int am_thr[2] = '{2, 1};

  logic [7:0] mq [2][$];
  logic [7:0] mqr[2];
  logic       mqv[2];
  logic       mof[2];
  logic       muf[2];

  fifo_sync_pf #(.DATA_WIDTH(8), .DEPTH(16), .ALMOST_FULL_THR(14), .ALMOST_MTY_THR(2)) dut_a (
    .clk(clk), .srst(srst), .wr(wr_a), .data(data_a), .rd(rd_a),
    .q(q_a), .q_valid(qv_a), .full(full_a), .almost_full(af_a), .mty(mty_a),
    .almost_mty(am_a), .count(count_a), .overflow(of_a), .underflow(uf_a)
  );

  fifo_sync_pf #(.DATA_WIDTH(8), .DEPTH(5), .ALMOST_FULL_THR(4), .ALMOST_MTY_THR(1)) dut_b (
    .clk(clk), .srst(srst), .wr(wr_b), .data(data_b), .rd(rd_b),
    .q(q_b), .q_valid(qv_b), .full(full_b), .almost_full(af_b), .mty(mty_b),
    .almost_mty(am_b), .count(count_b), .overflow(of_b), .underflow(uf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int k, input string t);
    logic [31:0] c, f, af, m, am, of, uf, qv, qq;
    int n;
    if (k == 0) begin
      c = 32'(count_a); f = 32'(full_a); af = 32'(af_a); m = 32'(mty_a); am = 32'(am_a);
      of = 32'(of_a); uf = 32'(uf_a); qv = 32'(qv_a); qq = 32'(q_a);
    end else begin
      c = 32'(count_b); f = 32'(full_b); af = 32'(af_b); m = 32'(mty_b); am = 32'(am_b);
      of = 32'(of_b); uf = 32'(uf_b); qv = 32'(qv_b); qq = 32'(q_b);
    end
    n = mq[k].size();
    chk({t, ":count"},       c,  32'(n));
    chk({t, ":full"},        f,  32'(n == depth[k]));
    chk({t, ":almost_full"}, af, 32'(n >= af_thr[k]));
    chk({t, ":mty"},         m,  32'(n == 0));
    chk({t, ":almost_mty"},  am, 32'(n <= am_thr[k]));
    chk({t, ":overflow"},    of, 32'(mof[k]));
    chk({t, ":underflow"},   uf, 32'(muf[k]));
`ifdef FIFO_FWFT_EN
    chk({t, ":q_valid"}, qv, 32'(n != 0));
    if (n != 0) chk({t, ":q"}, qq, 32'(mq[k][0]));
`else
    chk({t, ":q_valid"}, qv, 32'(mqv[k]));
    chk({t, ":q"},       qq, 32'(mqr[k]));
`endif
  endtask

  task automatic do_reset(input string t);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mqr[k] = '0;
      mqv[k] = 1'b0;
      mof[k] = 1'b0;
      muf[k] = 1'b0;
    end
    check_all(0, {t, "_a"});
    check_all(1, {t, "_b"});
  endtask

  task automatic step(input int k, input logic w, input logic r, input logic [7:0] d, input string t);
    logic wacc, racc;
    if (k == 0) begin wr_a = w; rd_a = r; data_a = d; end
    else        begin wr_b = w; rd_b = r; data_b = d; end
    @(posedge clk);
    wacc = w && (mq[k].size() < depth[k]);
    racc = r && (mq[k].size() > 0);
    if (w && !wacc) mof[k] = 1'b1;
    if (r && !racc) muf[k] = 1'b1;
    mqv[k]   = racc;
    mqv[1-k] = 1'b0;
    if (racc) mqr[k] = mq[k].pop_front();
    if (wacc) mq[k].push_back(d);
    #1;
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
    check_all(k, t);
  endtask

  initial begin
    clk = 1'b0; srst = 1'b0;
    wr_a = 1'b0; rd_a = 1'b0; data_a = '0;
    wr_b = 1'b0; rd_b = 1'b0; data_b = '0;
    @(posedge clk);
    #1;

    do_reset("reset");

    for (int i = 1; i <= 16; i++) step(0, 1'b1, 1'b0, 8'(i), "fill16");
    chk("fill16:full_direct", 32'(full_a), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1'b0, 1'b1, 8'h00, "drain16");
`ifndef FIFO_FWFT_EN
      chk("drain16:q_order", 32'(q_a), 32'(i));
`endif
    end
    chk("drain16:mty_direct", 32'(mty_a), 32'd1);

    for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 8'(8'h40 + i), "refill");
    step(0, 1'b1, 1'b1, 8'hAA, "full_wr_rd");
    chk("full_wr_rd:count15", 32'(count_a), 32'd15);
    chk("full_wr_rd:overflow", 32'(of_a), 32'd1);
    for (int i = 0; i < 15; i++) step(0, 1'b0, 1'b1, 8'h00, "drain_noaa");

    step(0, 1'b1, 1'b1, 8'h55, "empty_wr_rd");
    chk("empty_wr_rd:underflow", 32'(uf_a), 32'd1);
    step(0, 1'b0, 1'b1, 8'h00, "read55");
`ifndef FIFO_FWFT_EN
    chk("read55:q", 32'(q_a), 32'h55);
`endif

    do_reset("reset2");
    step(1, 1'b1, 1'b0, 8'hC0, "d5_pre");
    step(1, 1'b1, 1'b0, 8'hC1, "d5_pre");
    for (int i = 0; i < 20; i++) step(1, 1'b1, 1'b1, 8'(8'hD0 + i), "d5_stream");
    chk("d5_stream:count2", 32'(count_b), 32'd2);

    for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 8'(8'h70 + i), "pre_srst");
    do_reset("mid_srst");
    step(0, 1'b1, 1'b0, 8'h33, "post_srst_wr33");
`ifdef FIFO_FWFT_EN
    chk("post_srst_wr33:q", 32'(q_a), 32'h33);
    chk("post_srst_wr33:q_valid", 32'(qv_a), 32'd1);
`endif

    do_reset("reset3");
    for (int i = 0; i < 600; i++) begin
      step(i % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
